// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/one_bit_fulladder.sv
// One-bit full adder built from two half adders and an OR of their carries.
module one_bit_fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  one_bit_halfadder u_ha0 (
    .i_a  (i_a),
    .i_b  (i_b),
    .o_s  (w_s1),
    .o_co (w_c1)
  );

  one_bit_halfadder u_ha1 (
    .i_a  (w_s1),
    .i_b  (i_ci),
    .o_s  (o_s),
    .o_co (w_c2)
  );

  assign o_co = w_c1 | w_c2;

endmodule

// File: rtl/one_bit_halfadder.sv
// One-bit half adder cell.
module one_bit_halfadder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b;
  assign o_co = i_a & i_b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder slice with a registered carry.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OV_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co
`ifdef SERIAL_ADDER_OV_EN
  ,
  output logic             o_ov
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_co;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_nxt;

  one_bit_fulladder u_fa (
    .i_a  (r_a_sh[0]),
    .i_b  (r_b_sh[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_c)
  );

  // New sum bit enters at the MSB so the LSB-first stream lands in place.
  assign w_sum_nxt = WIDTH'({w_s, r_sum} >> 1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        o_done = 1'b1;
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= i_a;
      r_b_sh  <= i_b;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= i_ci;
      r_co    <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_sum   <= w_sum_nxt;
      r_cnt   <= r_cnt + 1'b1;
      r_carry <= w_c;
      if (w_last) r_co <= w_c;
    end
  end

`ifdef SERIAL_ADDER_OV_EN
  // Carry into the MSB slice, kept so OV = c_in(msb) ^ c_out(msb) holds with S/CO.
  logic r_c_msb;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                         r_c_msb <= 1'b0;
    else if (w_accept)                 r_c_msb <= 1'b0;
    else if (w_last)                   r_c_msb <= r_carry;
  end

  assign o_ov = r_c_msb ^ r_co;
`endif

  assign o_s  = r_sum;
  assign o_co = r_co;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (WIDTH=8); OV checks follow SERIAL_ADDER_OV_EN.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
`ifdef SERIAL_ADDER_OV_EN
  logic         ov;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_ci    (ci),
    .o_busy  (busy),
    .o_done  (done),
    .o_s     (s),
    .o_co    (co)
`ifdef SERIAL_ADDER_OV_EN
    ,
    .o_ov    (ov)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] exp_s;
    logic         exp_co;
    logic         exp_ov;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for DONE; returns number of edges waited.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 40) begin
      tick();
      cycles++;
    end
    check("done_within_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic do_add(input vec_t v, input int idx);
    int cyc;
    int busy_cnt;
    logic [W-1:0] held;
    @(negedge clk);
    a = v.a; b = v.b; ci = v.ci; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      tick();
      cyc++;
    end
    check($sformatf("v%0d_latency", idx), cyc, W);
    check($sformatf("v%0d_busy_cycles", idx), busy_cnt, W);
    check($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
    check($sformatf("v%0d_s", idx), {24'd0, s}, {24'd0, v.exp_s});
    check($sformatf("v%0d_co", idx), {31'd0, co}, {31'd0, v.exp_co});
`ifdef SERIAL_ADDER_OV_EN
    check($sformatf("v%0d_ov", idx), {31'd0, ov}, {31'd0, v.exp_ov});
`endif
    held = s;
    tick();
    check($sformatf("v%0d_done_single", idx), {31'd0, done}, 32'd0);
    tick();
    check($sformatf("v%0d_s_hold_idle", idx), {24'd0, s}, {24'd0, v.exp_s});
    check($sformatf("v%0d_co_hold_idle", idx), {31'd0, co}, {31'd0, v.exp_co});
  endtask

  initial begin
    int c1;
    int c2;
    int ndone;

    //            a      b      ci    s      co    ov
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};
    vecs[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[9] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_s", {24'd0, s}, 32'd0);
    check("rst_co", {31'd0, co}, 32'd0);
`ifdef SERIAL_ADDER_OV_EN
    check("rst_ov", {31'd0, ov}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) do_add(vecs[i], i);

    // START during RUN must be ignored.
    @(negedge clk);
    a = 8'h0F; b = 8'h01; ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    @(negedge clk);
    a = 8'h11; b = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'h00; b = 8'h00;
    check("ign_busy", {31'd0, busy}, 32'd1);
    wait_done(c1);
    check("ign_latency", c1 + 3, W);
    check("ign_s", {24'd0, s}, 32'h10);
    check("ign_co", {31'd0, co}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check("ign_single_done", ndone, 0);

    // START held high: back-to-back results W+1 cycles apart.
    @(negedge clk);
    a = 8'h01; b = 8'h01; ci = 1'b0; start = 1'b1;
    tick();
    a = 8'h80; b = 8'h80;
    wait_done(c1);
    check("b2b_first_latency", c1, W);
    check("b2b_first_s", {24'd0, s}, 32'h02);
    check("b2b_first_co", {31'd0, co}, 32'd0);
    tick();
    start = 1'b0;
    check("b2b_reload_busy", {31'd0, busy}, 32'd1);
    wait_done(c2);
    check("b2b_spacing", c2 + 1, W + 1);
    check("b2b_second_s", {24'd0, s}, 32'h00);
    check("b2b_second_co", {31'd0, co}, 32'd1);
`ifdef SERIAL_ADDER_OV_EN
    check("b2b_second_ov", {31'd0, ov}, 32'd1);
`endif
    tick(); tick();

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_s", {24'd0, s}, 32'd0);
    check("mid_rst_co", {31'd0, co}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    do_add(vecs[8], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1, "timeout");
  end

endmodule
